// File: rtl/mov_wide_pipe.sv
// mov_wide_pipe: two-stage MOVZ / MOVN / MOVK wide-immediate pipeline.
//
// Stage A captures the request fields. Stage B captures the computed result.
// A request accepted at one edge is presented on out_valid two cycles later.
// Both stages hold their contents while downstream is stalled, so nothing is
// dropped or duplicated under backpressure.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake
//   in_op               00 MOVZ, 01 MOVN, 10 MOVK, 11 reserved (flagged illegal)
//   in_hw               chunk index, shift = in_hw*IMM_W
//   in_sf               1 = full DATA_W result, 0 = half-width result
//   in_imm              immediate chunk
//   in_old              previous destination value (MOVK only)
//   out_valid/out_ready result handshake
//   out_result, out_err result and illegal-request flag
//   op_count            saturating count of completed output handshakes
//
// Build option: define MOV_WIDE_PIPE_TRACE_EN to print each nonzero or
// erroring result as it is handed off (simulation only).

module mov_wide_pipe #(
  parameter int DATA_W = 64,
  parameter int IMM_W  = 16,
  localparam int HW_W  = $clog2(DATA_W / IMM_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [HW_W-1:0]   in_hw,
  input  logic              in_sf,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_old,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_err,
  output logic [15:0]       op_count
);

  localparam int HALF_CHUNKS = (DATA_W / 2) / IMM_W;

  localparam logic [1:0] OP_MOVZ = 2'b00;
  localparam logic [1:0] OP_MOVN = 2'b01;
  localparam logic [1:0] OP_MOVK = 2'b10;

  logic              a_valid_q, a_valid_d;
  logic [1:0]        a_op_q, a_op_d;
  logic [HW_W-1:0]   a_hw_q, a_hw_d;
  logic              a_sf_q, a_sf_d;
  logic [IMM_W-1:0]  a_imm_q, a_imm_d;
  logic [DATA_W-1:0] a_old_q, a_old_d;

  logic              b_valid_q, b_valid_d;
  logic [DATA_W-1:0] b_result_q, b_result_d;
  logic              b_err_q, b_err_d;

  logic [15:0]       op_count_q, op_count_d;

  logic              b_ready, in_fire, a_to_b, out_fire;
  int                shift;
  logic [DATA_W-1:0] imm_ext, imm_mask, calc_result;
  logic              calc_err;

  always_comb begin
    b_ready  = !b_valid_q || out_ready;
    // Equivalent to !A_valid || !B_valid || out_ready.
    in_ready = !a_valid_q || b_ready;
    in_fire  = in_valid && in_ready;
    a_to_b   = a_valid_q && b_ready;
    out_fire = b_valid_q && out_ready;
  end

  // Result computation from the stage A registers.
  always_comb begin
    shift    = int'(a_hw_q) * IMM_W;
    imm_ext  = {{(DATA_W-IMM_W){1'b0}}, a_imm_q} << shift;
    imm_mask = {{(DATA_W-IMM_W){1'b0}}, {IMM_W{1'b1}}} << shift;
    calc_err = (a_op_q == 2'b11) || (!a_sf_q && (int'(a_hw_q) >= HALF_CHUNKS));
    case (a_op_q)
      OP_MOVZ: calc_result = imm_ext;
      OP_MOVN: calc_result = ~imm_ext;
      OP_MOVK: calc_result = (a_old_q & ~imm_mask) | imm_ext;
      default: calc_result = '0;
    endcase
    // Half-width mode clears the upper half after the op (MOVN included).
    if (!a_sf_q) calc_result[DATA_W-1:DATA_W/2] = '0;
    if (calc_err) calc_result = '0;
  end

  always_comb begin
    a_valid_d = a_valid_q;
    a_op_d    = a_op_q;
    a_hw_d    = a_hw_q;
    a_sf_d    = a_sf_q;
    a_imm_d   = a_imm_q;
    a_old_d   = a_old_q;
    // in_fire with A occupied implies A is moving to B in the same edge.
    if (in_fire) begin
      a_valid_d = 1'b1;
      a_op_d    = in_op;
      a_hw_d    = in_hw;
      a_sf_d    = in_sf;
      a_imm_d   = in_imm;
      a_old_d   = in_old;
    end else if (a_to_b) begin
      a_valid_d = 1'b0;
    end

    b_valid_d  = b_valid_q;
    b_result_d = b_result_q;
    b_err_d    = b_err_q;
    if (a_to_b) begin
      b_valid_d  = 1'b1;
      b_result_d = calc_result;
      b_err_d    = calc_err;
    end else if (out_fire) begin
      b_valid_d = 1'b0;
    end

    op_count_d = op_count_q;
    if (out_fire && (op_count_q != 16'hFFFF)) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q  <= 1'b0;
      a_op_q     <= '0;
      a_hw_q     <= '0;
      a_sf_q     <= 1'b0;
      a_imm_q    <= '0;
      a_old_q    <= '0;
      b_valid_q  <= 1'b0;
      b_result_q <= '0;
      b_err_q    <= 1'b0;
      op_count_q <= '0;
    end else begin
      a_valid_q  <= a_valid_d;
      a_op_q     <= a_op_d;
      a_hw_q     <= a_hw_d;
      a_sf_q     <= a_sf_d;
      a_imm_q    <= a_imm_d;
      a_old_q    <= a_old_d;
      b_valid_q  <= b_valid_d;
      b_result_q <= b_result_d;
      b_err_q    <= b_err_d;
      op_count_q <= op_count_d;
    end
  end

  assign out_valid  = b_valid_q;
  assign out_result = b_result_q;
  assign out_err    = b_err_q;
  assign op_count   = op_count_q;

`ifdef MOV_WIDE_PIPE_TRACE_EN
  // Request fields follow the result into stage B purely for the trace print.
  logic [1:0]       tr_op_q;
  logic [HW_W-1:0]  tr_hw_q;
  logic             tr_sf_q;
  logic [IMM_W-1:0] tr_imm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tr_op_q  <= '0;
      tr_hw_q  <= '0;
      tr_sf_q  <= 1'b0;
      tr_imm_q <= '0;
    end else if (a_to_b) begin
      tr_op_q  <= a_op_q;
      tr_hw_q  <= a_hw_q;
      tr_sf_q  <= a_sf_q;
      tr_imm_q <= a_imm_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && out_fire && (b_err_q || (b_result_q != '0))) begin
      $display("mov_wide_pipe trace: op=%0d hw=%0d sf=%0b imm=%h result=%h err=%0b",
               tr_op_q, tr_hw_q, tr_sf_q, tr_imm_q, b_result_q, b_err_q);
    end
  end
`else
  // Default build carries no trace logic.
`endif

endmodule

// File: tb/tb_mov_wide_pipe.sv
module tb_mov_wide_pipe;
  localparam int DATA_W = 64;
  localparam int IMM_W  = 16;
  localparam int HW_W   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_op = '0;
  logic [HW_W-1:0]   in_hw = '0;
  logic              in_sf = 1'b0;
  logic [IMM_W-1:0]  in_imm = '0;
  logic [DATA_W-1:0] in_old = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_result;
  logic              out_err;
  logic [15:0]       op_count;

  int total = 0;
  int bad   = 0;
  int ready_mode = 0;        // 0: out_ready high, 1: random, 2: low
  logic [64:0] sb[$];        // {err, result}

  mov_wide_pipe #(.DATA_W(DATA_W), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_hw(in_hw), .in_sf(in_sf), .in_imm(in_imm), .in_old(in_old),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Reference model: chunk arithmetic on plain 64-bit numbers.
  function automatic logic [64:0] model(input logic [1:0] op, input int hw, input logic sf,
                                        input logic [15:0] imm, input logic [63:0] old);
    logic [63:0] w, chunk, r;
    if (op == 2'd3 || (!sf && hw >= 2)) return {1'b1, 64'd0};
    w = 64'd1 << (16 * hw);
    case (op)
      2'd0:    r = 64'(imm) * w;
      2'd1:    r = ~(64'(imm) * w);
      default: begin
        chunk = (old / w) % 64'd65536;
        r = old - chunk * w + 64'(imm) * w;
      end
    endcase
    if (!sf) r = r % (64'd1 << 32);
    return {1'b0, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: condition not met within cycle budget", name);
  endtask

  task automatic step(input logic v, input logic [1:0] op, input logic [1:0] hw, input logic sf,
                      input logic [15:0] imm, input logic [63:0] old, output logic acc);
    @(negedge clk);
    in_valid = v; in_op = op; in_hw = hw; in_sf = sf; in_imm = imm; in_old = old;
    out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    #1;
    acc = v && in_ready;
    if (acc) sb.push_back(model(op, int'(hw), sf, imm, old));
    @(posedge clk);
  endtask

  task automatic idle;
    logic acc;
    step(1'b0, 2'd0, 2'd0, 1'b0, 16'd0, 64'd0, acc);
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] hw, input logic sf,
                       input logic [15:0] imm, input logic [63:0] old);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      step(1'b1, op, hw, sf, imm, old, acc);
      n++;
    end
    if (!acc) fail_now("issue_accept");
  endtask

  task automatic issue_rand;
    logic [1:0] op;
    op = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    issue(op, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom),
          {$urandom, $urandom});
  endtask

  task automatic drain;
    int n;
    n = 0;
    ready_mode = 0;
    while (sb.size() != 0 && n < 100) begin
      idle();
      n++;
    end
    if (sb.size() != 0) fail_now("drain");
  endtask

  task automatic settle;
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  // Single isolated request: checks 2-cycle latency and the literal result.
  task automatic directed(input string name, input logic [1:0] op, input logic [1:0] hw,
                          input logic sf, input logic [15:0] imm, input logic [63:0] old,
                          input logic [63:0] er, input logic ee);
    ready_mode = 0;
    issue(op, hw, sf, imm, old);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk({name, "_valid_c1"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk({name, "_valid_c2"}, 64'(out_valid), 64'd1);
    chk({name, "_result"}, out_result, er);
    chk({name, "_err"}, 64'(out_err), 64'(ee));
    @(posedge clk);
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks stall stability.
  initial begin : monitor
    logic        held;
    logic [63:0] hres;
    logic        herr;
    logic [64:0] e;
    held = 1'b0;
    hres = '0;
    herr = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held && out_valid) begin
          chk("stall_result", out_result, hres);
          chk("stall_err", 64'(out_err), 64'(herr));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got result %h with no request outstanding", out_result);
          end else begin
            e = sb.pop_front();
            chk("sb_result", out_result, e[63:0]);
            chk("sb_err", 64'(out_err), 64'(e[64]));
          end
          held = 1'b0;
        end else if (out_valid) begin
          held = 1'b1;
          hres = out_result;
          herr = out_err;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int n_iss;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);

    directed("movz_beef", 2'd0, 2'd2, 1'b1, 16'hBEEF, 64'd0, 64'h0000_BEEF_0000_0000, 1'b0);
    directed("movk", 2'd2, 2'd1, 1'b1, 16'hABCD, 64'h1111_2222_3333_4444,
             64'h1111_2222_ABCD_4444, 1'b0);
    directed("movn_half", 2'd1, 2'd0, 1'b0, 16'h0000, 64'hDEAD_BEEF_DEAD_BEEF,
             64'h0000_0000_FFFF_FFFF, 1'b0);
    directed("err_hw", 2'd0, 2'd2, 1'b0, 16'h1234, 64'd0, 64'd0, 1'b1);
    directed("err_op", 2'd3, 2'd0, 1'b1, 16'h5678, 64'd0, 64'd0, 1'b1);
    settle();
    chk("count_directed", 64'(op_count), 64'd5);

    // Eight back-to-back requests under random backpressure.
    reset_dut();
    ready_mode = 1;
    for (int i = 0; i < 8; i++) issue_rand();
    drain();
    settle();
    chk("count_burst8", 64'(op_count), 64'd8);

    // Random traffic with gaps and random backpressure.
    ready_mode = 1;
    n_iss = 0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        issue_rand();
        n_iss++;
      end else begin
        idle();
      end
    end
    drain();
    settle();
    chk("count_random", 64'(op_count), 64'(8 + n_iss));

    // Fill both stages, then reset while handshakes are also offered.
    ready_mode = 2;
    issue(2'd0, 2'd1, 1'b1, 16'h00AA, 64'd0);
    issue(2'd1, 2'd0, 1'b1, 16'h0055, 64'd0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_op = 2'd0; in_hw = 2'd0; in_sf = 1'b1; in_imm = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sb.delete();
    #1;
    chk("rstfull_out_valid", 64'(out_valid), 64'd0);
    chk("rstfull_op_count", 64'(op_count), 64'd0);
    chk("rstfull_in_ready", 64'(in_ready), 64'd1);
    chk("rstfull_out_err", 64'(out_err), 64'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rstfull_no_ghost", 64'(out_valid), 64'd0);

    // Saturation of op_count.
    reset_dut();
    ready_mode = 0;
    for (int i = 0; i < 65535; i++) issue(2'd0, 2'($urandom_range(0, 3)), 1'b1, 16'($urandom), 64'd0);
    drain();
    settle();
    chk("count_ffff", 64'(op_count), 64'hFFFF);
    issue(2'd0, 2'd0, 1'b1, 16'h0001, 64'd0);
    issue(2'd3, 2'd0, 1'b1, 16'h0001, 64'd0);
    drain();
    settle();
    chk("count_saturate", 64'(op_count), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mov_wide_pipe.md
MOV_WIDE_PIPE -- requirements
Module: mov_wide_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 64, datapath width in bits; legal values are 32, 64 and 128.
REQ-002 SHALL have parameter IMM_W, default 16, immediate chunk width in bits; DATA_W/2 SHALL be a multiple of IMM_W.
REQ-003 SHALL derive localparam HW_W = clog2(DATA_W/IMM_W), the chunk-select width.
REQ-004 SHALL have port clk  input  1  rising-edge clock; one clock only.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high at a clk edge.
REQ-008 SHALL have port in_op  input  2  operation: 00 MOVZ, 01 MOVN, 10 MOVK, 11 reserved.
REQ-009 SHALL have port in_hw  input  HW_W  chunk index; shift = in_hw*IMM_W.
REQ-010 SHALL have port in_sf  input  1  1 = full DATA_W mode; 0 = half-width (DATA_W/2) mode.
REQ-011 SHALL have port in_imm  input  IMM_W  immediate chunk.
REQ-012 SHALL have port in_old  input  DATA_W  previous destination value, used by MOVK only.
REQ-013 SHALL have port out_valid  output  1  result present.
REQ-014 SHALL have port out_ready  input  1  consumer accepts.
REQ-015 SHALL have port out_result  output  DATA_W  computed value.
REQ-016 SHALL have port out_err  output  1  the request was illegal.
REQ-017 SHALL have port op_count  output  16  number of completed output handshakes.

Function
REQ-018 SHALL be a two-stage pipeline: stage A registers the request fields, stage B registers the result; latency from acceptance to out_valid is 2 cycles.
REQ-019 SHALL sustain one request per cycle while out_ready is held high.
REQ-020 SHALL drive in_ready = !A_valid || !B_valid || out_ready, so that no request is dropped or duplicated under backpressure.
REQ-021 SHALL hold out_result and out_err stable while out_valid=1 and out_ready=0.
REQ-022 SHALL compute MOVZ as zero-extend(imm) << shift.
REQ-023 SHALL compute MOVN as ~(zero-extend(imm) << shift).
REQ-024 SHALL compute MOVK as in_old with bits [shift+IMM_W-1:shift] replaced by imm and all other bits unchanged.
REQ-025 SHALL, when in_sf=0, force bits [DATA_W-1:DATA_W/2] of the result to zero after the operation, including for MOVN.
REQ-026 SHALL flag the request as illegal when in_sf=0 and in_hw >= (DATA_W/2)/IMM_W, or when in_op=11; an illegal request SHALL produce out_err=1 and out_result=0.
REQ-027 SHALL increment op_count on each out_valid&&out_ready edge, saturating at 16'hFFFF, and SHALL count erroring results as well.

Reset
REQ-028 SHALL, on rst=1 at a clk edge, clear both stage valids, out_result, out_err and op_count to 0; any request in flight is discarded.
REQ-029 SHALL drive in_ready=1 during the first cycle after rst deasserts.
REQ-030 SHALL give rst priority over a simultaneous handshake.

Configuration
REQ-031 SHALL, with macro MOV_WIDE_PIPE_TRACE_EN defined, print op, hw, sf, imm and result in simulation at every output handshake whose result is nonzero or erroring.
REQ-032 SHALL, without MOV_WIDE_PIPE_TRACE_EN, contain no display code; the RTL SHALL behave identically in both builds.

Verification
REQ-033 SHALL cover: MOVZ, imm=16'hBEEF, hw=2, sf=1, out_ready=1 -> out_result=64'h0000_BEEF_0000_0000, out_valid exactly 2 cycles after acceptance.
REQ-034 SHALL cover: MOVK, old=64'h1111_2222_3333_4444, imm=16'hABCD, hw=1 -> 64'h1111_2222_ABCD_4444; then MOVN, imm=0, hw=0, sf=0 -> 64'h0000_0000_FFFF_FFFF.
REQ-035 SHALL cover: sf=0, hw=2, MOVZ -> out_err=1, out_result=0; op=11 -> out_err=1; op_count increments for both.
REQ-036 SHALL cover: 8 back-to-back requests with out_ready toggling randomly -> all 8 results delivered in order, none lost or duplicated, outputs stable during stalls, op_count=8.
REQ-037 SHALL cover: rst asserted with both stages full -> out_valid=0 and op_count=0 on the next cycle, in_ready=1; a preloaded op_count of 16'hFFFF does not wrap on a further handshake.
